fios_operand_io: RTL and testbench

- Host-side counterpart of the FIOS multiplier top; it answers the multiplier's operand and result handshakes.
- Stores s words each of operands a, b and p, loaded by the host, and pulses start to the multiplier.
- Presents the a window and serves the b and p words on the multiplier's fetch and shift strobes.
- Collects the s result words pushed by the multiplier and streams them back to the host with a valid/ready handshake.

---
 rtl/fios_operand_io.sv | 190 +++++++++++++++++++
 tb/tb_fios_operand_io.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fios_operand_io.sv
// Host-side operand store and result collector for the FIOS multiplier.
// Loads a/b/p words, serves them on multiplier strobes, drains results.
module fios_operand_io #(
    parameter int s          = 8,
    parameter int WORD_WIDTH = 17,
    parameter int PE_NB      = 8
) (
    input  logic                        clock_i,
    input  logic                        reset_n_i,
    input  logic                        load_valid_i,
    output logic                        load_ready_o,
    input  logic [1:0]                  load_sel_i,
    input  logic [WORD_WIDTH-1:0]       load_word_i,
    input  logic                        go_i,
    output logic                        busy_o,
    output logic                        err_o,
    output logic                        start_o,
    output logic [PE_NB*WORD_WIDTH-1:0] a_o,
    input  logic                        a_shift_i,
    output logic [WORD_WIDTH-1:0]       b_o,
    input  logic                        b_fetch_i,
    output logic [WORD_WIDTH-1:0]       p_o,
    input  logic                        p_fetch_i,
    input  logic [WORD_WIDTH-1:0]       RES_i,
    input  logic                        RES_push_i,
    input  logic                        done_i,
    output logic                        res_valid_o,
    input  logic                        res_ready_i,
    output logic [WORD_WIDTH-1:0]       res_word_o,
    output logic                        res_last_o
);

    localparam int IW  = (s > 1) ? $clog2(s) : 1;
    localparam int CW  = $clog2(s + 1);
    localparam int ABW = $clog2(3 * s + 1);

    localparam logic [IW-1:0]  LAST   = IW'(s - 1);
    localparam logic [CW-1:0]  FULL   = CW'(s);
    localparam logic [ABW-1:0] A_END  = ABW'(s);
    localparam logic [ABW-1:0] A_STEP = ABW'(PE_NB);

    typedef enum logic [1:0] {IDLE, START, BUSY, DRAIN} state_t;

    state_t state;

    logic [WORD_WIDTH-1:0] a_mem   [s];
    logic [WORD_WIDTH-1:0] b_mem   [s];
    logic [WORD_WIDTH-1:0] p_mem   [s];
    logic [WORD_WIDTH-1:0] res_mem [s];

    logic [CW-1:0]  wa, wb, wp, sel_ptr, res_cnt, cnt_final;
    logic [ABW-1:0] a_base, a_win;
    logic [IW-1:0]  b_idx, p_idx, rd_idx;
    logic           idle, busy_st, drain;
    logic           sel_full, load_ok, load_bad, all_full, push_ok;

    assign idle    = (state == IDLE);
    assign busy_st = (state == BUSY);
    assign drain   = (state == DRAIN);

    always_comb begin
        sel_ptr = '0;
        case (load_sel_i)
            2'd0:    sel_ptr = wa;
            2'd1:    sel_ptr = wb;
            2'd2:    sel_ptr = wp;
            default: sel_ptr = '0;
        endcase
    end

    assign sel_full  = (sel_ptr == FULL);
    assign load_ok   = idle & load_valid_i & (load_sel_i != 2'd3) & ~sel_full;
    assign load_bad  = idle & load_valid_i & (load_sel_i != 2'd3) & sel_full;
    assign all_full  = (wa == FULL) & (wb == FULL) & (wp == FULL);
    assign push_ok   = busy_st & RES_push_i & (res_cnt != FULL);
    assign cnt_final = res_cnt + CW'(push_ok);

    // Storage arrays carry no reset; only pointers define validity.
    always_ff @(posedge clock_i) begin
        if (load_ok) begin
            case (load_sel_i)
                2'd0:    a_mem[sel_ptr[IW-1:0]] <= load_word_i;
                2'd1:    b_mem[sel_ptr[IW-1:0]] <= load_word_i;
                2'd2:    p_mem[sel_ptr[IW-1:0]] <= load_word_i;
                default: ;
            endcase
        end
        if (push_ok)
            res_mem[res_cnt[IW-1:0]] <= RES_i;
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state   <= IDLE;
            wa      <= '0;
            wb      <= '0;
            wp      <= '0;
            a_base  <= '0;
            b_idx   <= '0;
            p_idx   <= '0;
            res_cnt <= '0;
            rd_idx  <= '0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load_ok) begin
                        case (load_sel_i)
                            2'd0:    wa <= wa + 1'b1;
                            2'd1:    wb <= wb + 1'b1;
                            2'd2:    wp <= wp + 1'b1;
                            default: ;
                        endcase
                    end
                    if (load_bad)
                        err_o <= 1'b1;
                    if (go_i) begin
                        if (all_full) begin
                            state <= START;
                            err_o <= 1'b0;
                        end else begin
                            err_o <= 1'b1;
                        end
                    end
                end
                START: begin
                    wa      <= '0;
                    wb      <= '0;
                    wp      <= '0;
                    a_base  <= '0;
                    b_idx   <= '0;
                    p_idx   <= '0;
                    res_cnt <= '0;
                    rd_idx  <= '0;
                    state   <= BUSY;
                end
                BUSY: begin
                    if (a_shift_i && a_base < A_END)
                        a_base <= a_base + A_STEP;
                    if (b_fetch_i)
                        b_idx <= (b_idx == LAST) ? '0 : b_idx + 1'b1;
                    if (p_fetch_i)
                        p_idx <= (p_idx == LAST) ? '0 : p_idx + 1'b1;
                    if (push_ok)
                        res_cnt <= res_cnt + 1'b1;
                    else if (RES_push_i)
                        err_o <= 1'b1;
                    if (done_i) begin
                        state <= DRAIN;
                        if (cnt_final != FULL)
                            err_o <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (res_ready_i) begin
                        if (rd_idx == LAST) begin
                            rd_idx <= '0;
                            state  <= IDLE;
                        end else begin
                            rd_idx <= rd_idx + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign a_win = busy_st ? a_base : '0;

    always_comb begin
        logic [ABW-1:0] ai;
        a_o = '0;
        for (int k = 0; k < PE_NB; k++) begin
            ai = a_win + ABW'(k);
            if (ai < A_END)
                a_o[k*WORD_WIDTH +: WORD_WIDTH] = a_mem[ai[IW-1:0]];
        end
    end

    assign b_o          = b_mem[busy_st ? b_idx : '0];
    assign p_o          = p_mem[busy_st ? p_idx : '0];
    assign load_ready_o = idle;
    assign busy_o       = ~idle;
    assign start_o      = (state == START);
    assign res_valid_o  = drain;
    assign res_word_o   = res_mem[rd_idx];
    assign res_last_o   = drain & (rd_idx == LAST);

endmodule

// File: tb/tb_fios_operand_io.sv
// Scoreboard bench for fios_operand_io with s=8, PE_NB=3.
// Expected b words and result words are queued at stimulus time.
module tb_fios_operand_io;

    localparam int S  = 8;
    localparam int WW = 17;
    localparam int PE = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_valid, load_ready, go, busy, err, start;
    logic [1:0]        load_sel;
    logic [WW-1:0]     load_word, b, p, res_in, res_word;
    logic [PE*WW-1:0]  a;
    logic              a_shift, b_fetch, p_fetch, res_push, done;
    logic              res_valid, res_ready, res_last;

    int n_chk  = 0;
    int n_fail = 0;
    logic [WW-1:0] exp_q [$];

    fios_operand_io #(.s(S), .WORD_WIDTH(WW), .PE_NB(PE)) dut (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .load_valid_i (load_valid),
        .load_ready_o (load_ready),
        .load_sel_i   (load_sel),
        .load_word_i  (load_word),
        .go_i         (go),
        .busy_o       (busy),
        .err_o        (err),
        .start_o      (start),
        .a_o          (a),
        .a_shift_i    (a_shift),
        .b_o          (b),
        .b_fetch_i    (b_fetch),
        .p_o          (p),
        .p_fetch_i    (p_fetch),
        .RES_i        (res_in),
        .RES_push_i   (res_push),
        .done_i       (done),
        .res_valid_o  (res_valid),
        .res_ready_i  (res_ready),
        .res_word_o   (res_word),
        .res_last_o   (res_last)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] win(input int w2, input int w1, input int w0);
        return (64'(w2) << (2 * WW)) | (64'(w1) << WW) | 64'(w0);
    endfunction

    task automatic load(input logic [1:0] sel, input int w);
        load_valid = 1'b1;
        load_sel   = sel;
        load_word  = WW'(w);
        tick();
        load_valid = 1'b0;
    endtask

    task automatic load_all(input int np);
        for (int i = 0; i < S; i++) load(2'd0, i + 1);
        for (int i = 0; i < S; i++) load(2'd1, 'h11 + i);
        for (int i = 0; i < np; i++) load(2'd2, 'h21 + i);
    endtask

    task automatic drain(input string tag);
        logic [3:0] pat;
        int guard;
        pat   = 4'b1001;
        guard = 0;
        while (exp_q.size() > 0 && guard < 100) begin
            chk({tag, "_valid"}, 64'(res_valid), 64'd1);
            chk({tag, "_word"}, 64'(res_word), 64'(exp_q[0]));
            res_ready = pat[guard % 4];
            if (res_ready) begin
                chk({tag, "_last"}, 64'(res_last), 64'(exp_q.size() == 1));
                void'(exp_q.pop_front());
            end
            guard++;
            tick();
        end
        res_ready = 1'b0;
        if (exp_q.size() != 0) begin
            chk({tag, "_timeout"}, 64'(exp_q.size()), 64'd0);
            exp_q.delete();
        end
        chk({tag, "_idle"}, 64'(busy), 64'd0);
    endtask

    initial begin
        rst_n = 1'b0; load_valid = 0; load_sel = 0; load_word = 0; go = 0;
        a_shift = 0; b_fetch = 0; p_fetch = 0; res_in = 0; res_push = 0;
        done = 0; res_ready = 0;
        #12;
        chk("rst_busy", 64'(busy), 0);
        chk("rst_ready", 64'(load_ready), 1);
        chk("rst_err", 64'(err), 0);
        chk("rst_start", 64'(start), 0);
        chk("rst_valid", 64'(res_valid), 0);
        rst_n = 1'b1;
        tick();

        load_all(S);
        go = 1'b1;
        tick();
        go = 1'b0;
        chk("start_hi", 64'(start), 1);
        chk("busy_hi", 64'(busy), 1);
        tick();
        chk("start_lo", 64'(start), 0);
        chk("a_win0", 64'(a), win(3, 2, 1));
        a_shift = 1'b1; tick();
        chk("a_win1", 64'(a), win(6, 5, 4));
        tick();
        chk("a_win2", 64'(a), win(0, 8, 7));
        tick();
        chk("a_win3", 64'(a), 0);
        tick();
        a_shift = 1'b0;
        chk("a_sat", 64'(a), 0);

        for (int i = 0; i < 9; i++) exp_q.push_back(WW'('h11 + (i % S)));
        for (int i = 0; i < 9; i++) begin
            chk("b_seq", 64'(b), 64'(exp_q.pop_front()));
            b_fetch = 1'b1; tick(); b_fetch = 1'b0;
        end
        chk("b_wrap", 64'(b), 'h12);
        chk("p_hold", 64'(p), 'h21);
        p_fetch = 1'b1; b_fetch = 1'b1; tick();
        p_fetch = 1'b0; b_fetch = 1'b0;
        chk("p_fetch", 64'(p), 'h22);
        chk("b_simul", 64'(b), 'h13);

        for (int i = 0; i < S; i++) begin
            res_in   = WW'('h100 + i);
            res_push = 1'b1;
            done     = (i == S - 1);
            exp_q.push_back(res_in);
            tick();
        end
        res_push = 1'b0; done = 1'b0;
        chk("drain_err", 64'(err), 0);
        drain("d1");

        load_all(S - 1);
        go = 1'b1; tick(); go = 1'b0;
        chk("go_short_busy", 64'(busy), 0);
        chk("go_short_err", 64'(err), 1);
        load(2'd2, 'h28);
        load(2'd2, 'h29);
        chk("ovf_load_err", 64'(err), 1);
        go = 1'b1; tick(); go = 1'b0;
        chk("err_clr", 64'(err), 0);
        tick();
        for (int i = 0; i < 6; i++) begin
            res_in = WW'('h200 + i); res_push = 1'b1;
            exp_q.push_back(res_in);
            tick();
        end
        res_push = 1'b0;
        exp_q.push_back(WW'('h106));
        exp_q.push_back(WW'('h107));
        done = 1'b1; tick(); done = 1'b0;
        chk("short_err", 64'(err), 1);
        drain("d2");

        load_all(S);
        go = 1'b1; tick(); go = 1'b0;
        tick();
        chk("pre_rst_busy", 64'(busy), 1);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 0);
        chk("arst_ready", 64'(load_ready), 1);
        chk("arst_err", 64'(err), 0);
        chk("arst_valid", 64'(res_valid), 0);
        #3 rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
